char_mem_sequencer: RTL and testbench

Sequencer for the shared 8-bit character/font block RAM: one port is time-shared between the VGA pixel pipeline (hard slots), CPU byte reads/writes and a hardware fill/scroll engine. Sits between the memory bus decode for the character page (0x8000), the pixel pipeline and the BRAM. It replaces ad-hoc `mem_rbusy` stalling with an explicit grant schedule, and offloads clear-screen and scroll-up from firmware.

---
 rtl/char_mem_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_char_mem_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_mem_sequencer.sv
// Purpose: time-shares the character/font BRAM port between video slots, CPU byte access and a fill/scroll engine.
// Latency: CPU write lands on the first free cycle after the strobe; CPU read data returns 2..4 cycles after the strobe.
// Backpressure: cpu_busy holds off further CPU strobes (extra strobes are dropped); eng_start is ignored while eng_busy.
// Build option: define CHARSEQ_SCROLL_EN to include the scroll-up states and hold register; otherwise fill only.
module char_mem_sequencer #(
    parameter int TEXT_CELLS = 3600,
    parameter int COLS       = 100
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        vid_own,
    input  logic [12:0] vid_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic        cpu_busy,
    input  logic        eng_start,
    input  logic        eng_op,
    input  logic [7:0]  eng_fill,
    output logic        eng_busy,
    output logic        eng_done,
    output logic [12:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    // The index counter and BRAM address are 13 bits; the text area and row pitch must fit inside it.
    if (COLS < 1 || COLS >= TEXT_CELLS || TEXT_CELLS > 8192) begin : g_cfg_check
        $error("char_mem_sequencer: need 1 <= COLS < TEXT_CELLS <= 8192");
    end

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FILL   = 3'd1;
`ifdef CHARSEQ_SCROLL_EN
    localparam logic [2:0] ST_SC_RD  = 3'd2;
    localparam logic [2:0] ST_SC_WR  = 3'd3;
    localparam logic [2:0] ST_SC_CLR = 3'd4;
`endif
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [12:0] LAST_CELL   = 13'(TEXT_CELLS - 1);
`ifdef CHARSEQ_SCROLL_EN
    localparam logic [12:0] LAST_SCROLL = 13'(TEXT_CELLS - COLS - 1);
    localparam logic [12:0] ROW_PITCH   = 13'(COLS);
`endif

    // ------------------------------------------------------------------
    // Slot arbitration: video owns the port outright; otherwise a pending
    // CPU request beats the engine.
    // ------------------------------------------------------------------
    logic        cpu_pend_q;
    logic        cpu_is_wr_q;
    logic [12:0] cpu_addr_q;
    logic [7:0]  cpu_wdata_q;
    logic        cpu_rwait_q;
    logic [7:0]  cpu_rdata_q;

    logic        free_slot;
    logic        cpu_gnt;
    logic        eng_slot;
    logic        cpu_accept;

    assign free_slot  = ~vid_own;
    assign cpu_gnt    = free_slot & cpu_pend_q;
    assign eng_slot   = free_slot & ~cpu_pend_q;
    assign cpu_busy   = cpu_pend_q | cpu_rwait_q;
    assign cpu_accept = (cpu_rd | cpu_wr) & ~cpu_busy;

    // Read data is forwarded straight from the BRAM in the rvalid cycle and held afterwards.
    assign cpu_rvalid = cpu_rwait_q;
    assign cpu_rdata  = cpu_rwait_q ? mem_rdata : cpu_rdata_q;

    // CPU request register: one deep, write wins a simultaneous read/write strobe.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            cpu_pend_q  <= 1'b0;
            cpu_is_wr_q <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
            cpu_rwait_q <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            if (cpu_accept) begin
                cpu_pend_q  <= 1'b1;
                cpu_is_wr_q <= cpu_wr;
                cpu_addr_q  <= cpu_addr;
                cpu_wdata_q <= cpu_wdata;
            end else if (cpu_gnt) begin
                cpu_pend_q  <= 1'b0;
            end
            cpu_rwait_q <= cpu_gnt & ~cpu_is_wr_q;
            if (cpu_rwait_q) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fill / scroll engine
    // ------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [12:0] idx_q, idx_d;
    logic [7:0]  fill_q, fill_d;
    logic        eng_we;
    logic [12:0] eng_addr;
    logic [7:0]  eng_wdata;
`ifdef CHARSEQ_SCROLL_EN
    logic [7:0]  hold_q, hold_d;
    logic        cap_q, cap_d;
    logic [7:0]  sc_data;

    // The capture cycle after a scroll read is spent already in SC_WR: the
    // write may use the live BRAM data in that cycle, so each scrolled cell
    // costs exactly two free cycles.
    assign sc_data = cap_q ? mem_rdata : hold_q;
`endif

    // Engine next-state, address and write strobe.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fill_d    = fill_q;
        eng_we    = 1'b0;
        eng_addr  = '0;
        eng_wdata = '0;
`ifdef CHARSEQ_SCROLL_EN
        hold_d    = hold_q;
        cap_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (eng_start) begin
                    fill_d = eng_fill;
                    idx_d  = '0;
`ifdef CHARSEQ_SCROLL_EN
                    state_d = eng_op ? ST_SC_RD : ST_FILL;
`else
                    state_d = eng_op ? ST_DONE : ST_FILL;
`endif
                end
            end
`ifdef CHARSEQ_SCROLL_EN
            ST_FILL, ST_SC_CLR: begin
`else
            ST_FILL: begin
`endif
                eng_addr = idx_q;
                if (eng_slot) begin
                    eng_we    = 1'b1;
                    eng_wdata = fill_q;
                    if (idx_q == LAST_CELL) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 13'd1;
                    end
                end
            end
`ifdef CHARSEQ_SCROLL_EN
            ST_SC_RD: begin
                eng_addr = idx_q + ROW_PITCH;
                if (eng_slot) begin
                    cap_d   = 1'b1;
                    state_d = ST_SC_WR;
                end
            end
            ST_SC_WR: begin
                eng_addr = idx_q;
                if (cap_q) begin
                    hold_d = mem_rdata;
                end
                if (eng_slot) begin
                    eng_we    = 1'b1;
                    eng_wdata = sc_data;
                    idx_d     = idx_q + 13'd1;
                    state_d   = (idx_q == LAST_SCROLL) ? ST_SC_CLR : ST_SC_RD;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine state registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            fill_q  <= '0;
`ifdef CHARSEQ_SCROLL_EN
            hold_q  <= '0;
            cap_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
`ifdef CHARSEQ_SCROLL_EN
            hold_q  <= hold_d;
            cap_q   <= cap_d;
`endif
        end
    end

    assign eng_busy = (state_q != ST_IDLE);
    assign eng_done = (state_q == ST_DONE);

    // ------------------------------------------------------------------
    // BRAM port mux. eng_we is only raised on eng_slot, so no write can
    // ever collide with a video slot.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (vid_own) begin
            mem_addr = vid_addr;
        end else if (cpu_gnt) begin
            mem_addr  = cpu_addr_q;
            mem_we    = cpu_is_wr_q;
            mem_wdata = cpu_is_wr_q ? cpu_wdata_q : 8'h00;
        end else begin
            mem_addr  = eng_addr;
            mem_we    = eng_we;
            mem_wdata = eng_wdata;
        end
    end

endmodule

// File: tb/tb_char_mem_sequencer.sv
module tb_char_mem_sequencer;
    localparam int TEXT_CELLS = 3600;
    localparam int COLS       = 100;
    localparam int MEM_SZ     = 8192;

    logic        clk = 1'b0;
    logic        resetq;
    logic        vid_own;
    logic [12:0] vid_addr;
    logic        cpu_rd, cpu_wr;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid, cpu_busy;
    logic        eng_start, eng_op;
    logic [7:0]  eng_fill;
    logic        eng_busy, eng_done;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    char_mem_sequencer #(.TEXT_CELLS(TEXT_CELLS), .COLS(COLS)) dut (
        .clk(clk), .resetq(resetq), .vid_own(vid_own), .vid_addr(vid_addr),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_busy(cpu_busy),
        .eng_start(eng_start), .eng_op(eng_op), .eng_fill(eng_fill),
        .eng_busy(eng_busy), .eng_done(eng_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- environment BRAM and reference memory ----------------
    logic [7:0] bram    [0:MEM_SZ-1];
    logic [7:0] ref_mem [0:MEM_SZ-1];
    bit         preload_req = 1'b0;

    function automatic logic [7:0] init_val(input int i);
        if (i < TEXT_CELLS) return 8'(i / COLS);
        return 8'(i) ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < MEM_SZ; i++) bram[i] <= init_val(i);
        end else if (mem_we) begin
            bram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= bram[mem_addr];
    end

    // ---------------- slot schedule model ----------------
    function automatic bit vid(input int c);
        return (c % 8) < 2;
    endfunction

    function automatic int next_free(input int c);
        int x;
        x = c;
        while (vid(x)) x++;
        return x;
    endfunction

    function automatic int nth_free(input int c, input int n);
        int x;
        x = c - 1;
        for (int k = 0; k < n; k++) x = next_free(x + 1);
        return x;
    endfunction

    initial begin
        vid_own  = 1'b1;
        vid_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            vid_own  = vid(cyc);
            vid_addr = 13'($urandom_range(0, MEM_SZ - 1));
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int cyc; logic [12:0] addr; logic [7:0] dat; } wr_t;
    typedef struct { int cyc; logic [7:0] dat; } rd_t;
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    int  exp_done[$];

    int busy_lo = 0, busy_hi = -1;
    int eng_lo = 0, eng_hi = -1;
    bit eng_act = 1'b0;
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk(cpu_busy === (cyc >= busy_lo && cyc <= busy_hi), "cpu_busy", int'(cpu_busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            chk(eng_busy === (cyc >= eng_lo && cyc <= eng_hi), "eng_busy", int'(eng_busy), int'(cyc >= eng_lo && cyc <= eng_hi));
            if (mem_we === 1'b1) begin
                chk(vid_own === 1'b0, "we_during_video", int'(vid_own), 0);
                if (!eng_act) begin
                    chk(exp_wr.size() > 0, "unexpected_write", exp_wr.size(), 1);
                    if (exp_wr.size() > 0) begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        chk(cyc == w.cyc, "cpu_write_cycle", cyc, w.cyc);
                        chk(mem_addr === w.addr, "cpu_write_addr", int'(mem_addr), int'(w.addr));
                        chk(mem_wdata === w.dat, "cpu_write_data", int'(mem_wdata), int'(w.dat));
                    end
                end
            end
            if (cpu_rvalid === 1'b1) begin
                chk(exp_rd.size() > 0, "unexpected_rvalid", exp_rd.size(), 1);
                if (exp_rd.size() > 0) begin
                    rd_t r;
                    r = exp_rd.pop_front();
                    chk(cyc == r.cyc, "cpu_rvalid_cycle", cyc, r.cyc);
                    chk(cpu_rdata === r.dat, "cpu_rdata", int'(cpu_rdata), int'(r.dat));
                end
            end
            if (eng_done === 1'b1) begin
                chk(exp_done.size() > 0, "unexpected_eng_done", exp_done.size(), 1);
                if (exp_done.size() > 0) begin
                    int d;
                    d = exp_done.pop_front();
                    chk(cyc == d, "eng_done_cycle", cyc, d);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        eng_start = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        tick();
        while ((cyc % 8) != p) tick();
    endtask

    task automatic cpu_req(input bit rd, input bit wr, input int addr, input int dat);
        int n, g;
        wr_t w;
        rd_t r;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = 13'(addr);
        cpu_wdata = 8'(dat);
        n = cyc;
        if (n > busy_hi) begin
            g = next_free(n + 1);
            busy_lo = n + 1;
            if (wr) begin
                w.cyc = g; w.addr = 13'(addr); w.dat = 8'(dat);
                exp_wr.push_back(w);
                ref_mem[addr] = 8'(dat);
                busy_hi = g;
            end else begin
                r.cyc = g + 1; r.dat = ref_mem[addr];
                exp_rd.push_back(r);
                busy_hi = g + 1;
            end
        end
    endtask

    task automatic start_eng(input bit op, input logic [7:0] f);
        int n, nfree, done;
        eng_start = 1'b1;
        eng_op    = op;
        eng_fill  = f;
        n = cyc;
        nfree = 0;
        if (!op) begin
            nfree = TEXT_CELLS;
            for (int i = 0; i < TEXT_CELLS; i++) ref_mem[i] = f;
            eng_act = 1'b1;
        end else begin
`ifdef CHARSEQ_SCROLL_EN
            nfree = 2 * (TEXT_CELLS - COLS) + COLS;
            for (int i = 0; i < TEXT_CELLS - COLS; i++) ref_mem[i] = ref_mem[i + COLS];
            for (int i = TEXT_CELLS - COLS; i < TEXT_CELLS; i++) ref_mem[i] = f;
            eng_act = 1'b1;
`endif
        end
        done = (nfree > 0) ? nth_free(n + 1, nfree) + 1 : n + 1;
        eng_lo = n + 1;
        eng_hi = done;
        exp_done.push_back(done);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((cyc <= eng_hi + 1 || cyc <= busy_hi + 1) && guard < 20000) begin
            tick();
            guard++;
        end
        chk(guard < 20000, "wait_idle_timeout", guard, 0);
        eng_act = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk(cpu_rdata === 8'h00, {tag, "_cpu_rdata"}, int'(cpu_rdata), 0);
        chk(cpu_rvalid === 1'b0, {tag, "_cpu_rvalid"}, int'(cpu_rvalid), 0);
        chk(cpu_busy === 1'b0, {tag, "_cpu_busy"}, int'(cpu_busy), 0);
        chk(eng_busy === 1'b0, {tag, "_eng_busy"}, int'(eng_busy), 0);
        chk(eng_done === 1'b0, {tag, "_eng_done"}, int'(eng_done), 0);
        chk(mem_we === 1'b0, {tag, "_mem_we"}, int'(mem_we), 0);
        chk(mem_wdata === 8'h00, {tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk(mem_addr === (vid_own ? vid_addr : 13'd0), {tag, "_mem_addr"}, int'(mem_addr), int'(vid_own ? vid_addr : 13'd0));
    endtask

    task automatic mem_check(input string tag);
        int bad, first;
        bad = 0;
        first = -1;
        for (int i = 0; i < MEM_SZ; i++) begin
            if (bram[i] !== ref_mem[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        chk(bad == 0, {tag, "_mem_mismatch_cells"}, bad, 0);
        if (first >= 0) $display("  first differing cell %0d: bram=0x%0h model=0x%0h", first, bram[first], ref_mem[first]);
    endtask

    task automatic preload();
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_val(i);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r_cyc;
        int kind;
        resetq    = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        eng_start = 1'b0;
        eng_op    = 1'b0;
        eng_fill  = '0;
        preload_req = 1'b1;
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_val(i);

        tick();
        preload_req = 1'b0;
        tick();
        @(negedge clk);
        check_reset_vals("reset");
        tick();
        resetq = 1'b1;
        mon_en = 1'b1;

        // Write at slot phase 7: granted at phase 2, busy for three cycles.
        wait_phase(7);
        cpu_req(1'b0, 1'b1, 5, 8'h41);
        tick();
        wait_idle();

        // Read at phase 2 returns in phase 4; a strobe while busy is dropped.
        wait_phase(2);
        cpu_req(1'b1, 1'b0, 5, 0);
        tick();
        cpu_req(1'b1, 1'b0, 7, 0);
        tick();
        wait_idle();
        @(negedge clk);
        chk(cpu_rdata === 8'h41, "cpu_rdata_held", int'(cpu_rdata), 8'h41);

        // Randomised CPU traffic, including strobes that land while busy.
        repeat (80) begin
            repeat ($urandom_range(0, 4)) tick();
            kind = int'($urandom_range(0, 2));
            cpu_req(kind != 1, kind != 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
            tick();
        end
        wait_idle();
        mem_check("cpu_random");

        // Scroll-up (or the degenerate no-write path when scrolling is not built in).
        preload();
        tick();
        start_eng(1'b1, 8'hEE);
        tick();
        wait_idle();
        mem_check("scroll");

        // Full fill; a second start while busy must be ignored.
        start_eng(1'b0, 8'h20);
        repeat (700) tick();
        eng_start = 1'b1;
        eng_op    = 1'b1;
        eng_fill  = 8'h99;
        tick();
        wait_idle();
        mem_check("fill");

        // Reset in the middle of an engine run, then a clean fill.
`ifdef CHARSEQ_SCROLL_EN
        start_eng(1'b1, 8'h55);
`else
        start_eng(1'b0, 8'h55);
`endif
        repeat (1000) tick();
        r_cyc = cyc;
        resetq = 1'b0;
        eng_hi = r_cyc;
        exp_done.delete();
        tick();
        resetq  = 1'b1;
        eng_act = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        tick();
        start_eng(1'b0, 8'h2E);
        tick();
        wait_idle();
        mem_check("fill_after_reset");

        repeat (4) tick();
        chk(exp_wr.size() == 0, "pending_writes_left", exp_wr.size(), 0);
        chk(exp_rd.size() == 0, "pending_reads_left", exp_rd.size(), 0);
        chk(exp_done.size() == 0, "pending_done_left", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
